// File: rtl/rvj1_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rvj1_wb_arbiter : two-master / one-slave Wishbone B4 classic arbiter      |
// | Optional hung-slave timeout: define RVJ1_WB_ARB_TIMEOUT_EN                |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module rvj1_wb_arbiter #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_gnt;   // 1 = M1 held the bus most recently
  logic   w_stb_raw;
  logic   w_timeout;
  logic   w_ack;

  if (TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("rvj1_wb_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == GNT0 && r_state != GNT0) begin
        r_last_gnt <= 1'b0;
      end else if (w_next == GNT1 && r_state != GNT1) begin
        r_last_gnt <= 1'b1;
      end
    end
  end

  // Grant is only ever surrendered voluntarily; a release hands straight over.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next = (PRIORITY_MODE != 0 || r_last_gnt) ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          w_next = GNT0;
        end else if (m1_cyc_i) begin
          w_next = GNT1;
        end
      end
      GNT0: if (!m0_cyc_i) w_next = m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_cyc_i) w_next = m0_cyc_i ? GNT0 : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    w_stb_raw = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    case (r_state)
      GNT0: begin
        s_cyc_o   = m0_cyc_i;
        w_stb_raw = m0_stb_i;
        s_we_o    = m0_we_i;
        s_sel_o   = m0_sel_i;
        s_adr_o   = m0_adr_i;
        s_dat_o   = m0_dat_i;
      end
      GNT1: begin
        s_cyc_o   = m1_cyc_i;
        w_stb_raw = m1_stb_i;
        s_we_o    = m1_we_i;
        s_sel_o   = m1_sel_i;
        s_adr_o   = m1_adr_i;
        s_dat_o   = m1_dat_i;
      end
      default: ;
    endcase
  end

`ifdef RVJ1_WB_ARB_TIMEOUT_EN
  localparam int                c_CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;

  assign w_timeout = w_stb_raw && !s_ack_i && (r_cnt == c_CNT_MAX);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !w_stb_raw || s_ack_i || w_timeout || (w_next != r_state)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // The strobe is withheld in the timeout cycle so the slave never sees a late beat.
  assign s_stb_o  = w_stb_raw & ~w_timeout;
  assign w_ack    = s_ack_i & s_stb_o;

  assign m0_ack_o = (r_state == GNT0) & w_ack;
  assign m1_ack_o = (r_state == GNT1) & w_ack;
  assign m0_err_o = (r_state == GNT0) & w_timeout;
  assign m1_err_o = (r_state == GNT1) & w_timeout;
  assign m0_dat_o = (r_state == GNT0) ? s_dat_i : 32'd0;
  assign m1_dat_o = (r_state == GNT1) ? s_dat_i : 32'd0;
  assign grant_o  = {r_state == GNT1, r_state == GNT0};

endmodule
`default_nettype wire
